// File: rtl/ball_hit_tracker_pkg.sv
// Shared types and constants for the ball hit tracker and its collision helpers.
// States, playfield geometry, parameter defaults and an unsigned abs-difference helper.
package ball_hit_tracker_pkg;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        HIT      = 2'd1,
        COOLDOWN = 2'd2,
        OVER     = 2'd3
    } state_t;

    localparam int SCREEN_W = 96;
    localparam int SCREEN_H = 64;
    localparam int X_W      = 7;
    localparam int Y_W      = 6;

    localparam int LIVES_DEF      = 3;
    localparam int HIT_R_DEF      = 2;
    localparam int COOL_TICKS_DEF = 30;

    // Coordinates are widened to 8 bits first, so the difference never wraps.
    function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/hit_box_cmp.sv
// Combinational square hit-box test: overlap when |dx|<=HIT_R and |dy|<=HIT_R.
// Zero latency; pure logic, no handshake.
module hit_box_cmp
    import ball_hit_tracker_pkg::*;
#(
    parameter int HIT_R = HIT_R_DEF
) (
    input  logic [X_W-1:0] a_x_i,
    input  logic [Y_W-1:0] a_y_i,
    input  logic [X_W-1:0] b_x_i,
    input  logic [Y_W-1:0] b_y_i,
    output logic           overlap_o
);

    logic [7:0] dx;
    logic [7:0] dy;

    assign dx        = abs_diff8(8'(a_x_i), 8'(b_x_i));
    assign dy        = abs_diff8(8'(a_y_i), 8'(b_y_i));
    assign overlap_o = (dx <= 8'(HIT_R)) && (dy <= 8'(HIT_R));

endmodule

// File: rtl/ball_hit_tracker.sv
// Lives/score tracker: tick-sampled ball vs player hit test, respawn pulse, cooldown window.
// Hit on tick N shows HIT, respawn and decremented lives at N+1. HIT_BLINK_EN enables sprite blink.
module ball_hit_tracker
    import ball_hit_tracker_pkg::*;
#(
    parameter int LIVES      = LIVES_DEF,
    parameter int HIT_R      = HIT_R_DEF,
    parameter int COOL_TICKS = COOL_TICKS_DEF,
    parameter int SCORE_W    = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               tick,
    input  logic [X_W-1:0]     ball_x,
    input  logic [Y_W-1:0]     ball_y,
    input  logic [X_W-1:0]     player_x,
    input  logic [Y_W-1:0]     player_y,
    output logic               respawn,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               invuln,
    output logic               game_over,
    output logic               blink
);

    state_t             state_q;
    logic [2:0]         lives_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_d;
    logic [7:0]         cool_cnt_q;
    logic               respawn_q;
    logic               invuln_q;
    logic               game_over_q;
    logic               overlap;

    hit_box_cmp #(.HIT_R(HIT_R)) u_hit_box (
        .a_x_i    (ball_x),
        .a_y_i    (ball_y),
        .b_x_i    (player_x),
        .b_y_i    (player_y),
        .overlap_o(overlap)
    );

    assign score_d = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + 1'b1;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= PLAY;
            lives_q     <= 3'(LIVES);
            score_q     <= '0;
            cool_cnt_q  <= '0;
            respawn_q   <= 1'b0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            respawn_q <= 1'b0;
            case (state_q)
                PLAY: begin
                    if (tick) begin
                        if (!overlap) begin
                            score_q <= score_d;
                        end else if (lives_q > 3'd1) begin
                            lives_q   <= lives_q - 3'd1;
                            state_q   <= HIT;
                            respawn_q <= 1'b1;
                            invuln_q  <= 1'b1;
                        end else begin
                            // Last life: straight to OVER, the ball is not respawned.
                            lives_q     <= 3'd0;
                            state_q     <= OVER;
                            game_over_q <= 1'b1;
                        end
                    end
                end
                HIT: begin
                    cool_cnt_q <= 8'(COOL_TICKS);
                    state_q    <= COOLDOWN;
                end
                COOLDOWN: begin
                    if (tick) begin
                        cool_cnt_q <= cool_cnt_q - 8'd1;
                        if (cool_cnt_q == 8'd1) begin
                            state_q  <= PLAY;
                            invuln_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HIT_BLINK_EN
    logic blink_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            blink_q <= 1'b1;
        end else begin
            case (state_q)
                PLAY: begin
                    if (tick && overlap) begin
                        blink_q <= 1'b0;
                    end else begin
                        blink_q <= 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (tick) begin
                        blink_q <= (cool_cnt_q == 8'd1) ? 1'b1 : ~blink_q;
                    end
                end
                OVER:    blink_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b1;
`endif

    assign respawn   = respawn_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign invuln    = invuln_q;
    assign game_over = game_over_q;

endmodule
